bcd_display_scanner: RTL and testbench

- Downstream consumer of the BCD adder outputs. It drives a multiplexed common-anode 7-segment display from N packed BCD digits, for example {s2, s1} from the adder.
- Captures digits on a load strobe. Applies them tear-free at frame boundaries.
- Time-multiplexes one digit per slot, with dead-time, leading-zero blanking and invalid-code indication.
- All outputs are registered and drive the board pins directly.

---
 rtl/bcd_display_scanner.sv | 155 +++++++++++++++
 tb/tb_bcd_display_scanner.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_scanner
//  Description : Multiplexed common-anode 7-segment driver for N packed BCD
//                digits. Digits are captured on a load strobe into a shadow
//                register and transferred to the display register only at
//                frame start, so a frame never shows a mix of old and new
//                digits. Each digit slot begins with one dead-time cycle.
//                Optional leading-zero blanking, and a dash for codes 10..15.
//  Ports       :
//    clk         in   1           system clock, rising edge
//    rst_n       in   1           asynchronous active-low reset
//    load        in   1           capture strobe for digits_in
//    digits_in   in   4*N_DIGITS  packed BCD, digit 0 = bits [3:0] (LSD)
//    blank_lz    in   1           1 = blank leading zeros (sampled live)
//    seg_n       out  7           active-low segments {g,f,e,d,c,b,a}
//    an_n        out  N_DIGITS    active-low one-hot digit enable
//    frame_done  out  1           one-cycle pulse on the last cycle of a scan
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner #(
  parameter int N_DIGITS    = 2,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done
);

  localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_DIGITS - 1);
  localparam logic [6:0] c_SEG_OFF = 7'h7F;

  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [4*N_DIGITS-1:0] r_display;

  logic [3:0]            w_digit;
  logic                  w_zero_run_sel;
  logic [N_DIGITS-1:0]   w_zero_from;
  logic                  w_run;
  logic [N_DIGITS-1:0]   w_an;
  logic                  w_blank;
  logic                  w_slot_end;
  logic                  w_frame_start;
  logic                  w_frame_last;

  // Active-low decode; codes above 9 show a dash (segment g only).
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign w_slot_end    = (r_cnt == c_CNT_LAST);
  assign w_frame_start = (r_cnt == '0) && (r_idx == '0);
  assign w_frame_last  = w_slot_end && (r_idx == c_IDX_LAST);

  // w_zero_from[i] is set when display digits N_DIGITS-1 down to i are all
  // zero; it is built from the most significant digit downwards.
  always_comb begin
    w_zero_from = '0;
    w_run       = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_run          = w_run && (r_display[4*i +: 4] == 4'd0);
      w_zero_from[i] = w_run;
    end
  end

  // Select the digit and anode for the current slot.
  always_comb begin
    w_digit        = 4'd0;
    w_zero_run_sel = 1'b0;
    w_an           = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_digit        = r_display[4*i +: 4];
        w_zero_run_sel = w_zero_from[i];
        w_an[i]        = 1'b0;
      end
    end
  end

  // Digit 0 is never blanked so a value of zero still shows "0".
  assign w_blank = blank_lz && (r_idx != '0) && w_zero_run_sel;

  // Prescale counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Shadow takes every load; display only changes at frame start, where a
  // load on that same edge bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_display <= '0;
    end else begin
      if (load) begin
        r_shadow <= digits_in;
      end
      if (w_frame_start) begin
        r_display <= load ? digits_in : r_shadow;
      end
    end
  end

  // Registered pin drivers: pins follow the counter state one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= c_SEG_OFF;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_last;
      if (r_cnt == '0) begin
        seg_n <= c_SEG_OFF;
        an_n  <= '1;
      end else begin
        seg_n <= w_blank ? c_SEG_OFF : f_decode(w_digit);
        an_n  <= w_an;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_scanner
//  Description : Directed self-checking bench for bcd_display_scanner with
//                N_DIGITS=2, REFRESH_DIV=4 (8-cycle frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

  localparam int N  = 2;
  localparam int RD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [7:0]   digits_in;
  logic         blank_lz;
  logic [6:0]   seg_n;
  logic [1:0]   an_n;
  logic         frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  task automatic check_pins(input string tag, input logic [1:0] ean,
                            input logic [6:0] eseg, input logic efd);
    checks++;
    assert (an_n === ean) else begin
      errors++;
      $error("FAIL %s an_n: got %b expected %b", tag, an_n, ean);
    end
    checks++;
    assert (seg_n === eseg) else begin
      errors++;
      $error("FAIL %s seg_n: got %h expected %h", tag, seg_n, eseg);
    end
    checks++;
    assert (frame_done === efd) else begin
      errors++;
      $error("FAIL %s frame_done: got %b expected %b", tag, frame_done, efd);
    end
  endtask

  // Called at a negedge just before a frame-start edge. Checks all 8 output
  // cycles of the frame; optional loads: one on the frame-start edge and two
  // mid-frame (captured at edges 2 and 6 of the frame).
  task automatic run_frame(input string tag,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input bit edge_ld, input logic [7:0] edge_val,
                           input bit lda, input logic [7:0] vala,
                           input bit ldb, input logic [7:0] valb);
    logic [1:0] ean;
    logic [6:0] eseg;
    int slot;
    int cyc;
    load = edge_ld;
    if (edge_ld) digits_in = edge_val;
    for (int k = 0; k < N * RD; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k == 1 && lda) begin load = 1'b1; digits_in = vala; end
      if (k == 5 && ldb) begin load = 1'b1; digits_in = valb; end
      slot = k / RD;
      cyc  = k % RD;
      if (cyc == 0) begin
        ean  = 2'b11;
        eseg = 7'h7F;
      end else begin
        ean  = (slot == 0) ? 2'b10 : 2'b01;
        eseg = (slot == 0) ? s0 : s1;
      end
      check_pins($sformatf("%s k%0d", tag, k), ean, eseg, (k == N * RD - 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    load      = 1'b0;
    digits_in = 8'h00;
    blank_lz  = 1'b0;
    #1 rst_n  = 1'b0;
    @(negedge clk);
    check_pins("reset", 2'b11, 7'h7F, 1'b0);
    rst_n = 1'b1;

    // "00" after reset; load 17 mid-frame must not show yet.
    run_frame("rst_00", 7'h40, 7'h40, 0, 8'h00, 1, 8'h17, 0, 8'h00);
    // 17 shows now; load 05 mid-frame for the next one.
    run_frame("show17", 7'h78, 7'h79, 0, 8'h00, 0, 8'h00, 1, 8'h05);
    blank_lz = 1'b1;
    run_frame("lz05", 7'h12, 7'h7F, 0, 8'h00, 1, 8'h00, 0, 8'h00);
    run_frame("lz00", 7'h40, 7'h7F, 0, 8'h00, 1, 8'hA3, 0, 8'h00);
    run_frame("lzA3", 7'h30, 7'h3F, 0, 8'h00, 0, 8'h00, 0, 8'h00);
    blank_lz = 1'b0;
    // Load on the frame-start edge shows in the same frame; two later loads.
    run_frame("edge42", 7'h24, 7'h19, 1, 8'h42, 1, 8'h11, 1, 8'h99);
    run_frame("last99", 7'h10, 7'h10, 0, 8'h00, 0, 8'h00, 0, 8'h00);

    // Move into the active part of the digit-1 slot, then reset between edges.
    repeat (6) @(negedge clk);
    check_pins("pre_rst", 2'b01, 7'h10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_pins("async_rst", 2'b11, 7'h7F, 1'b0);
    @(negedge clk);
    check_pins("held_rst", 2'b11, 7'h7F, 1'b0);
    rst_n = 1'b1;
    run_frame("post_rst", 7'h40, 7'h40, 0, 8'h00, 0, 8'h00, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
